// File: rtl/inst_loader.sv
// Boot-time program loader: turns a length-prefixed byte stream into 32-bit
// instruction memory writes and holds the core in reset until a clean load.
module inst_loader #(
  parameter int MEM_BYTES = 16384,
  parameter int TIMEOUT   = 1000000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        byte_valid_i,
  input  logic [7:0]  byte_data_i,
  output logic        byte_ready_o,
  output logic        imem_wren_o,
  output logic [31:0] imem_addr_o,
  output logic [31:0] imem_wdata_o,
  output logic        cpu_rst_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  output logic [15:0] words_o
);

  localparam int            MAX_WORDS = MEM_BYTES / 4;
  localparam int            IW        = $clog2(TIMEOUT + 1);
  localparam logic [IW-1:0] IDLE_LAST = IW'(TIMEOUT - 1);
  localparam logic [16:0]   MAX_LEN   = 17'(MAX_WORDS);

  typedef enum logic [1:0] {LEN_LO, LEN_HI, DATA, DONE} state_t;

  state_t        state;
  logic [15:0]   len;
  logic [1:0]    byte_cnt;
  logic [23:0]   partial;
  logic [IW-1:0] idle;

  logic        accept;
  logic        in_frame;
  logic        frame_end;
  logic        finish_ok;
  logic        finish_err;
  logic [15:0] hdr_len;

  assign accept    = byte_valid_i && byte_ready_o;
  assign in_frame  = (state == LEN_HI) || (state == DATA);
  assign frame_end = (state == DATA) && (words_o == len);
  assign hdr_len   = {byte_data_i, len[7:0]};

  // A completed frame wins over a timeout that expires in the same cycle.
  assign finish_ok  = frame_end ||
                      ((state == LEN_HI) && accept && (hdr_len == 16'd0));
  assign finish_err = !frame_end &&
                      (((state == LEN_HI) && accept && ({1'b0, hdr_len} > MAX_LEN)) ||
                       (in_frame && !accept && (idle == IDLE_LAST)));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state        <= LEN_LO;
      len          <= '0;
      byte_cnt     <= '0;
      partial      <= '0;
      idle         <= '0;
      byte_ready_o <= 1'b1;
      imem_wren_o  <= 1'b0;
      imem_addr_o  <= '0;
      imem_wdata_o <= '0;
      cpu_rst_o    <= 1'b1;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
      err_o        <= 1'b0;
      words_o      <= '0;
    end else begin
      imem_wren_o <= 1'b0;
      if (in_frame) begin
        idle <= accept ? '0 : idle + IW'(1);
      end
      case (state)
        LEN_LO: begin
          if (accept) begin
            len[7:0] <= byte_data_i;
            idle     <= '0;
            busy_o   <= 1'b1;
            state    <= LEN_HI;
          end
        end
        LEN_HI: begin
          if (accept) begin
            len[15:8] <= byte_data_i;
            state     <= DATA;
          end
        end
        DATA: begin
          if (accept && !frame_end) begin
            byte_cnt <= byte_cnt + 2'd1;
            case (byte_cnt)
              2'd0: partial[7:0]   <= byte_data_i;
              2'd1: partial[15:8]  <= byte_data_i;
              2'd2: partial[23:16] <= byte_data_i;
              default: begin
                imem_wren_o  <= 1'b1;
                imem_addr_o  <= {14'd0, words_o, 2'b00};
                imem_wdata_o <= {byte_data_i, partial};
                words_o      <= words_o + 16'd1;
              end
            endcase
          end
        end
        DONE: begin
          if (start_i) begin
            state        <= LEN_LO;
            err_o        <= 1'b0;
            words_o      <= '0;
            byte_cnt     <= '0;
            idle         <= '0;
            cpu_rst_o    <= 1'b1;
            done_o       <= 1'b0;
            byte_ready_o <= 1'b1;
          end
        end
      endcase
      // Shared exit into DONE; overrides whatever the case above scheduled.
      if (finish_ok || finish_err) begin
        state        <= DONE;
        busy_o       <= 1'b0;
        done_o       <= 1'b1;
        byte_ready_o <= 1'b0;
        err_o        <= finish_err;
        cpu_rst_o    <= finish_err;
      end
    end
  end

endmodule
